// File: rtl/fht_frame_sched_if.sv
// Bus bundle between the frame scheduler and its environment: sample loader,
// frame RAM write port, fht_control handshake and result unloader.
interface fht_frame_sched_if #(
  parameter int A_BIT = 9,
  parameter int D_BIT = 16
);
  logic               iSAMPLE_VALID;
  logic [D_BIT-1:0]   iSAMPLE;
  logic               oLD_EN;
  logic               oLD_BUF;
  logic [A_BIT+1:0]   oLD_ADDR;
  logic [D_BIT-1:0]   oLD_DATA;
  logic               oFHT_START;
  logic               oFHT_BUF;
  logic               iFHT_RDY;
  logic               oOUT_VALID;
  logic               iOUT_READY;
  logic               oOUT_BUF;
  logic [A_BIT+1:0]   oOUT_ADDR;
  logic               oOUT_LAST;
  logic               oOVF;
  logic [15:0]        oDROP_CNT;

  // scheduler side
  modport master (
    input  iSAMPLE_VALID, iSAMPLE, iFHT_RDY, iOUT_READY,
    output oLD_EN, oLD_BUF, oLD_ADDR, oLD_DATA, oFHT_START, oFHT_BUF,
           oOUT_VALID, oOUT_BUF, oOUT_ADDR, oOUT_LAST, oOVF, oDROP_CNT
  );

  // environment side
  modport slave (
    output iSAMPLE_VALID, iSAMPLE, iFHT_RDY, iOUT_READY,
    input  oLD_EN, oLD_BUF, oLD_ADDR, oLD_DATA, oFHT_START, oFHT_BUF,
           oOUT_VALID, oOUT_BUF, oOUT_ADDR, oOUT_LAST, oOVF, oDROP_CNT
  );
endinterface

// File: rtl/fht_frame_sched.sv
// Ping-pong frame scheduler for the FHT core. Two frame buffers cycle through
// FREE -> FULL -> BUSY -> DONE -> FREE; independent load, transform and unload
// pointers follow the buffers in order, so frame order is preserved.
module fht_frame_sched #(
  parameter int A_BIT = 9,
  parameter int D_BIT = 16
) (
  input logic               iCLK,
  input logic               iRESET,
  fht_frame_sched_if.master bus
);
  localparam int            CW       = A_BIT + 2;
  localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};

  typedef enum logic [1:0] {B_FREE, B_FULL, B_BUSY, B_DONE} buf_state_t;
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} fsm_state_t;

  buf_state_t       bstate [2];
  logic             ld_ptr, fht_ptr, out_ptr;
  logic [CW-1:0]    ld_cnt, out_cnt;
  fsm_state_t       state, state_next;
  logic             fht_start;

  logic             ld_take, ld_drop, ld_wrap;
  logic             fht_go, fht_fin;
  logic             out_valid, out_fire, out_wrap;

  logic             ld_en_p1, ld_buf_p1;
  logic [CW-1:0]    ld_addr_p1;
  logic [D_BIT-1:0] ld_data_p1;
  logic             ovf;
  logic [15:0]      drop_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Phase events; each one only ever addresses the buffer its own pointer
  // selects, and the state rules keep those buffers distinct.
  assign ld_take   = bus.iSAMPLE_VALID && (bstate[ld_ptr] == B_FREE);
  assign ld_drop   = bus.iSAMPLE_VALID && (bstate[ld_ptr] != B_FREE);
  assign ld_wrap   = ld_take && (ld_cnt == CNT_LAST);
  assign fht_go    = (state == S_START);
  assign fht_fin   = (state == S_WAIT_DONE) && bus.iFHT_RDY;
  assign out_valid = (bstate[out_ptr] == B_DONE);
  assign out_fire  = out_valid && bus.iOUT_READY;
  assign out_wrap  = out_fire && (out_cnt == CNT_LAST);

  // Load stage: register the accepted sample with its address, count drops.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      ld_en_p1   <= 1'b0;
      ld_buf_p1  <= 1'b0;
      ld_addr_p1 <= '0;
      ld_data_p1 <= '0;
      ld_cnt     <= '0;
      ld_ptr     <= 1'b0;
      ovf        <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      ld_en_p1 <= ld_take;
      if (ld_take) begin
        ld_buf_p1  <= ld_ptr;
        ld_addr_p1 <= ld_cnt;
        ld_data_p1 <= bus.iSAMPLE;
        ld_cnt     <= ld_wrap ? '0 : ld_cnt + 1'b1;
        if (ld_wrap) ld_ptr <= ~ld_ptr;
      end
      if (ld_drop) begin
        ovf      <= 1'b1;
        drop_cnt <= sat_inc16(drop_cnt);
      end
    end
  end

  // Transform pointer advances once the engine reports completion.
  always_ff @(posedge iCLK) begin
    if (iRESET)       fht_ptr <= 1'b0;
    else if (fht_fin) fht_ptr <= ~fht_ptr;
  end

  // Unload index advances on each accepted address, wrapping per frame.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      out_cnt <= '0;
      out_ptr <= 1'b0;
    end else if (out_fire) begin
      out_cnt <= out_wrap ? '0 : out_cnt + 1'b1;
      if (out_wrap) out_ptr <= ~out_ptr;
    end
  end

  // Buffer ownership: all three phases may update in one cycle.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      bstate[0] <= B_FREE;
      bstate[1] <= B_FREE;
    end else begin
      if (ld_wrap)  bstate[ld_ptr]  <= B_FULL;
      if (fht_go)   bstate[fht_ptr] <= B_BUSY;
      if (fht_fin)  bstate[fht_ptr] <= B_DONE;
      if (out_wrap) bstate[out_ptr] <= B_FREE;
    end
  end

  // FSM state register.
  always_ff @(posedge iCLK) begin
    if (iRESET) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next state; RDY is ignored in START so a slow RDY drop is not missed.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if ((bstate[fht_ptr] == B_FULL) && bus.iFHT_RDY) state_next = S_START;
      S_START:     state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!bus.iFHT_RDY) state_next = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.iFHT_RDY)  state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // FSM outputs: start pulse decoded from the registered state.
  always_comb begin
    fht_start = 1'b0;
    if (state == S_START) fht_start = 1'b1;
  end

  assign bus.oLD_EN     = ld_en_p1;
  assign bus.oLD_BUF    = ld_buf_p1;
  assign bus.oLD_ADDR   = ld_addr_p1;
  assign bus.oLD_DATA   = ld_data_p1;
  assign bus.oFHT_START = fht_start;
  assign bus.oFHT_BUF   = fht_ptr;
  assign bus.oOUT_VALID = out_valid;
  assign bus.oOUT_BUF   = out_ptr;
  assign bus.oOUT_ADDR  = out_cnt;
  assign bus.oOUT_LAST  = out_valid && (out_cnt == CNT_LAST);
  assign bus.oOVF       = ovf;
  assign bus.oDROP_CNT  = drop_cnt;
endmodule

// File: tb/tb_fht_frame_sched.sv
// Bench for fht_frame_sched with 16-sample frames. A frame-count model
// (frames loaded / started / transformed / unloaded) predicts every output
// each cycle; directed scenarios add hand-computed literal expectations.
module tb_fht_frame_sched;
  localparam int A_BIT = 2;
  localparam int D_BIT = 16;
  localparam int FL    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fht_frame_sched_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();
  fht_frame_sched #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // model: frame counters plus the engine handshake phase
  int m_nl, m_ns, m_nd, m_nu, m_lcnt, m_ocnt, m_ph;
  int e_ld_en, e_ld_buf, e_ld_addr, e_ld_data, e_ovf, e_drop;

  // FHT engine emulation
  bit fht_auto;
  int fht_len;
  int rdy_cnt;

  // event logs
  int ld_n, st_n, un_n, last_n;
  int ld_addr_log [512];
  int ld_buf_log  [512];
  int st_buf_log  [64];
  int un_addr_log [512];
  int un_buf_log  [512];
  int un_last_log [512];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  nl0, nu0, nd0;
    bit  fire;
    if (rst) begin
      m_nl = 0; m_ns = 0; m_nd = 0; m_nu = 0; m_lcnt = 0; m_ocnt = 0; m_ph = 0;
      e_ld_en = 0; e_ld_buf = 0; e_ld_addr = 0; e_ld_data = 0; e_ovf = 0; e_drop = 0;
    end else begin
      nl0  = m_nl;
      nu0  = m_nu;
      nd0  = m_nd;
      fire = (nu0 < nd0) && bus.iOUT_READY;
      e_ld_en = 0;
      if (bus.iSAMPLE_VALID) begin
        if (nl0 - nu0 < 2) begin
          e_ld_en   = 1;
          e_ld_buf  = nl0 % 2;
          e_ld_addr = m_lcnt;
          e_ld_data = int'(bus.iSAMPLE);
          if (m_lcnt == FL - 1) begin m_nl++; m_lcnt = 0; end
          else m_lcnt++;
        end else begin
          e_ovf = 1;
          if (e_drop < 65535) e_drop++;
        end
      end
      case (m_ph)
        0: if (m_ns < nl0 && bus.iFHT_RDY) m_ph = 1;
        1: begin m_ns++; m_ph = 2; end
        2: if (!bus.iFHT_RDY) m_ph = 3;
        3: if (bus.iFHT_RDY) begin m_nd++; m_ph = 0; end
        default: m_ph = 0;
      endcase
      if (fire) begin
        if (m_ocnt == FL - 1) begin m_nu++; m_ocnt = 0; end
        else m_ocnt++;
      end
    end
  endtask

  task automatic compare();
    int v;
    v = (m_nu < m_nd) ? 1 : 0;
    chk("ld_en",     int'(bus.oLD_EN),     e_ld_en);
    chk("ld_buf",    int'(bus.oLD_BUF),    e_ld_buf);
    chk("ld_addr",   int'(bus.oLD_ADDR),   e_ld_addr);
    chk("ld_data",   int'(bus.oLD_DATA),   e_ld_data);
    chk("fht_start", int'(bus.oFHT_START), (m_ph == 1) ? 1 : 0);
    chk("fht_buf",   int'(bus.oFHT_BUF),   m_nd % 2);
    chk("out_valid", int'(bus.oOUT_VALID), v);
    chk("out_buf",   int'(bus.oOUT_BUF),   m_nu % 2);
    chk("out_addr",  int'(bus.oOUT_ADDR),  m_ocnt);
    chk("out_last",  int'(bus.oOUT_LAST),  (v == 1 && m_ocnt == FL - 1) ? 1 : 0);
    chk("ovf",       int'(bus.oOVF),       e_ovf);
    chk("drop_cnt",  int'(bus.oDROP_CNT),  e_drop);
  endtask

  // One clock: log the handshake as it stands before the edge, advance the
  // model on the edge, compare after it, then log events and run the engine.
  task automatic tick();
    if (bus.oOUT_VALID && bus.iOUT_READY && un_n < 512) begin
      un_addr_log[un_n] = int'(bus.oOUT_ADDR);
      un_buf_log[un_n]  = int'(bus.oOUT_BUF);
      un_last_log[un_n] = int'(bus.oOUT_LAST);
      un_n++;
      if (bus.oOUT_LAST) last_n++;
    end
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (bus.oLD_EN && ld_n < 512) begin
      ld_addr_log[ld_n] = int'(bus.oLD_ADDR);
      ld_buf_log[ld_n]  = int'(bus.oLD_BUF);
      ld_n++;
    end
    if (bus.oFHT_START && st_n < 64) begin
      st_buf_log[st_n] = int'(bus.oFHT_BUF);
      st_n++;
    end
    if (fht_auto) begin
      if (rdy_cnt > 0) begin
        rdy_cnt--;
        if (rdy_cnt == 0) bus.iFHT_RDY = 1'b1;
      end else if (bus.oFHT_START) begin
        bus.iFHT_RDY = 1'b0;
        rdy_cnt      = fht_len;
      end
    end
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.iSAMPLE_VALID = 1'b0;
    fht_auto          = 1'b0;
    rdy_cnt           = 0;
    bus.iFHT_RDY      = 1'b1;
    bus.iOUT_READY    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic feed(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.iSAMPLE_VALID = 1'b1;
      bus.iSAMPLE       = 16'(base + i);
      tick();
    end
    bus.iSAMPLE_VALID = 1'b0;
  endtask

  task automatic wait_unl(input int target, input int budget, input string name);
    int b;
    b = budget;
    while (un_n < target && b > 0) begin tick(); b--; end
    chk(name, un_n, target);
  endtask

  task automatic wait_start(input int target, input int budget, input string name);
    int b;
    b = budget;
    while (st_n < target && b > 0) begin tick(); b--; end
    chk(name, st_n, target);
  endtask

  initial begin
    int b_ld, b_st, b_un, b_last;
    ld_n = 0; st_n = 0; un_n = 0; last_n = 0;
    bus.iSAMPLE_VALID = 1'b0;
    bus.iSAMPLE       = '0;
    bus.iFHT_RDY      = 1'b1;
    bus.iOUT_READY    = 1'b1;
    fht_auto = 1'b0;
    fht_len  = 20;
    rdy_cnt  = 0;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ld_en",     int'(bus.oLD_EN),     0);
    chk("rst_ld_data",   int'(bus.oLD_DATA),   0);
    chk("rst_fht_start", int'(bus.oFHT_START), 0);
    chk("rst_out_valid", int'(bus.oOUT_VALID), 0);
    chk("rst_drop_cnt",  int'(bus.oDROP_CNT),  0);
    rst = 1'b0;

    // single frame, 20-cycle transform
    fht_auto = 1'b1; fht_len = 20;
    b_ld = ld_n; b_st = st_n; b_un = un_n; b_last = last_n;
    feed(FL, 100);
    wait_unl(b_un + FL, 150, "t1_unload_count");
    for (int i = 0; i < FL; i++) begin
      chk("t1_ld_addr", ld_addr_log[b_ld + i], i);
      chk("t1_ld_buf",  ld_buf_log[b_ld + i],  0);
      chk("t1_un_addr", un_addr_log[b_un + i], i);
    end
    chk("t1_starts",    st_n - b_st, 1);
    chk("t1_start_buf", st_buf_log[b_st], 0);
    chk("t1_last_cnt",  last_n - b_last, 1);
    chk("t1_last_at15", un_last_log[b_un + FL - 1], 1);

    // back-to-back frames, 40-cycle transform
    do_reset();
    fht_auto = 1'b1; fht_len = 40;
    b_ld = ld_n; b_st = st_n; b_un = un_n;
    feed(2 * FL, 200);
    wait_unl(b_un + 2 * FL, 300, "t2_unload_count");
    chk("t2_frame2_buf", ld_buf_log[b_ld + FL], 1);
    chk("t2_starts",     st_n - b_st, 2);
    chk("t2_start0_buf", st_buf_log[b_st], 0);
    chk("t2_start1_buf", st_buf_log[b_st + 1], 1);
    chk("t2_un0_buf",    un_buf_log[b_un], 0);
    chk("t2_un1_buf",    un_buf_log[b_un + FL], 1);

    // overflow: unloader stalled, 40 samples offered
    do_reset();
    fht_auto = 1'b1; fht_len = 5;
    bus.iOUT_READY = 1'b0;
    b_ld = ld_n; b_un = un_n;
    feed(40, 300);
    chk("t3_writes",   ld_n - b_ld, 32);
    chk("t3_ovf",      int'(bus.oOVF), 1);
    chk("t3_drop_cnt", int'(bus.oDROP_CNT), 8);
    bus.iOUT_READY = 1'b1;
    wait_unl(b_un + 2 * FL, 200, "t3_drain");

    // backpressure: ready toggles every cycle
    do_reset();
    fht_auto = 1'b1; fht_len = 4;
    bus.iOUT_READY = 1'b0;
    b_un = un_n; b_last = last_n;
    feed(FL, 400);
    for (int k = 0; k < 200 && un_n < b_un + FL; k++) begin
      bus.iOUT_READY = ~bus.iOUT_READY;
      tick();
    end
    chk("t4_unload_count", un_n - b_un, FL);
    for (int i = 0; i < FL; i++) chk("t4_un_addr", un_addr_log[b_un + i], i);
    chk("t4_last_cnt", last_n - b_last, 1);
    bus.iOUT_READY = 1'b1;

    // RDY stays high after START: no DONE until low then high
    do_reset();
    b_st = st_n; b_un = un_n;
    feed(FL, 500);
    wait_start(b_st + 1, 10, "t5a_start");
    repeat (3) tick();
    chk("t5a_no_done", int'(bus.oOUT_VALID), 0);
    bus.iFHT_RDY = 1'b0;
    tick();
    tick();
    bus.iFHT_RDY = 1'b1;
    tick();
    chk("t5a_done_valid", int'(bus.oOUT_VALID), 1);
    chk("t5a_done_addr",  int'(bus.oOUT_ADDR),  0);
    wait_unl(b_un + FL, 40, "t5a_drain");

    // RDY low while FULL: START withheld
    do_reset();
    bus.iFHT_RDY = 1'b0;
    b_st = st_n; b_un = un_n;
    feed(FL, 600);
    repeat (5) tick();
    chk("t5b_withheld", st_n - b_st, 0);
    bus.iFHT_RDY = 1'b1;
    wait_start(b_st + 1, 10, "t5b_start");
    bus.iFHT_RDY = 1'b0;
    repeat (3) tick();
    bus.iFHT_RDY = 1'b1;
    wait_unl(b_un + FL, 40, "t5b_drain");

    // reset while waiting for the transform to finish
    do_reset();
    fht_auto = 1'b1; fht_len = 30;
    b_st = st_n;
    feed(FL, 700);
    wait_start(b_st + 1, 10, "t6_start");
    repeat (5) tick();
    rst = 1'b1;
    fht_auto = 1'b0; rdy_cnt = 0; bus.iFHT_RDY = 1'b1;
    tick();
    chk("t6_rst_ld_addr",   int'(bus.oLD_ADDR),   0);
    chk("t6_rst_ld_data",   int'(bus.oLD_DATA),   0);
    chk("t6_rst_fht_start", int'(bus.oFHT_START), 0);
    chk("t6_rst_out_valid", int'(bus.oOUT_VALID), 0);
    rst = 1'b0;
    fht_auto = 1'b1; fht_len = 6;
    b_ld = ld_n; b_un = un_n;
    feed(FL, 800);
    chk("t6_first_addr", ld_addr_log[b_ld], 0);
    chk("t6_first_buf",  ld_buf_log[b_ld], 0);
    chk("t6_last_addr",  ld_addr_log[b_ld + FL - 1], FL - 1);
    wait_unl(b_un + FL, 80, "t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fht_frame_sched.md
# fht_frame_sched

Frame scheduler for the FHT core: owns two ping-pong frame buffers and shares them between the sample loader, the FHT engine (`fht_control` plus datapath) and the result unloader. It issues load addresses for incoming samples and starts one transform per filled frame. It tracks `fht_control`'s RDY handshake and streams unload addresses for finished frames. Frame order is preserved end to end.

## Interface
- `A_BIT`, default 9: bank address width; frame length `FRAME_LEN` = 4·2^A_BIT samples (4 banks).
- `D_BIT`, default 16: sample width.
- `iCLK`, in, 1: clock; all logic on posedge.
- `iRESET`, in, 1: synchronous, active-high reset.
- `iSAMPLE_VALID`, in, 1: one input sample this cycle.
- `iSAMPLE`, in, D_BIT: sample data.
- `oLD_EN`, out, 1: write strobe to frame RAM.
- `oLD_BUF`, out, 1: target buffer for the write.
- `oLD_ADDR`, out, A_BIT+2: linear sample index in the frame.
- `oLD_DATA`, out, D_BIT: registered copy of `iSAMPLE`.
- `oFHT_START`, out, 1: one-cycle start pulse to `fht_control`.
- `oFHT_BUF`, out, 1: buffer routed to the FHT datapath.
- `iFHT_RDY`, in, 1: `fht_control` RDY; high when idle.
- `oOUT_VALID`, out, 1: unload address valid.
- `iOUT_READY`, in, 1: unloader accepts the address.
- `oOUT_BUF`, out, 1: buffer being unloaded.
- `oOUT_ADDR`, out, A_BIT+2: unload index.
- `oOUT_LAST`, out, 1: high with the last index of a frame.
- `oOVF`, out, 1: sticky; a sample was dropped.
- `oDROP_CNT`, out, 16: saturating count of dropped samples.

## Operation
- Each buffer has a 2-bit state: FREE → FULL → BUSY → DONE → FREE.
- Three 1-bit pointers: `ld_ptr`, `fht_ptr`, `out_ptr`. Each toggles only when its phase completes on its buffer.
- **Load**
  - A sample is written when `iSAMPLE_VALID` is high and `buf[ld_ptr]` is FREE.
  - It is registered to `oLD_*` with `oLD_EN`=1, `oLD_ADDR`=ld_cnt, and ld_cnt increments.
  - On ld_cnt = FRAME_LEN-1, the same edge sets `buf[ld_ptr]` to FULL, toggles `ld_ptr` and clears ld_cnt.
  - If `buf[ld_ptr]` is not FREE, the sample is dropped: `oOVF` is set and `oDROP_CNT` increments, saturating at 0xFFFF. `oLD_EN` stays 0.
- **FHT FSM**
  - IDLE: when `buf[fht_ptr]`=FULL and `iFHT_RDY`=1, go to START.
  - START (1 cycle): `oFHT_START`=1, buffer becomes BUSY. Go to WAIT_BUSY.
  - WAIT_BUSY: stay until `iFHT_RDY`=0, then go to WAIT_DONE. `iFHT_RDY` is not sampled in the START cycle.
  - WAIT_DONE: stay until `iFHT_RDY`=1, then set the buffer to DONE, toggle `fht_ptr` and return to IDLE.
  - `oFHT_BUF`=`fht_ptr` at all times and holds stable from START to the end of WAIT_DONE.
- **Unload**
  - `oOUT_VALID` = (`buf[out_ptr]`==DONE), decoded from registers.
  - `oOUT_ADDR`=out_cnt and `oOUT_BUF`=`out_ptr`.
  - On VALID&READY, out_cnt increments. At FRAME_LEN-1 (`oOUT_LAST`=1), the buffer becomes FREE, `out_ptr` toggles and out_cnt clears.
- Buffer states are mutually exclusive per phase, so load, FHT and unload updates in the same cycle always touch different buffers and all take effect.
- A buffer freed by unload can accept a load write on the next cycle.

## Timing
- Reset values:
  - Both buffers FREE; all pointers and counters 0; FSM in IDLE.
  - `oLD_EN`=0, `oLD_BUF`=0, `oLD_ADDR`=0, `oLD_DATA`=0.
  - `oFHT_START`=0, `oFHT_BUF`=0.
  - `oOUT_VALID`=0, `oOUT_BUF`=0, `oOUT_ADDR`=0, `oOUT_LAST`=0.
  - `oOVF`=0, `oDROP_CNT`=0.
- Reset asserted mid-frame or mid-FHT aborts everything to the reset state the next edge. No start pulse is issued during reset.
- Load latency is 1 cycle from `iSAMPLE_VALID` to `oLD_EN`.
- Last write to `oFHT_START`:
  - Minimum 1 cycle: FULL is set on the last-write edge and the START state is entered on the next edge.
  - The pulse is delayed while `iFHT_RDY`=0.
- WAIT_DONE exit to `oOUT_VALID`=1 is 1 cycle (DONE registered).
- Unload has zero-latency handshake; `oOUT_ADDR` holds while VALID&!READY.

## Test plan
- **Single frame** (A_BIT=2, FRAME_LEN=16): 16 consecutive valid samples.
  - `oLD_ADDR` runs 0..15 on buffer 0.
  - One `oFHT_START` on buffer 0.
  - Model RDY low for 20 cycles; then 16 `oOUT_ADDR` values 0..15 with `oOUT_LAST` on 15.
- **Back-to-back frames**: 32 continuous samples with a 40-cycle FHT.
  - Frame 2 loads into buffer 1 during the FHT of buffer 0.
  - Starts alternate buffer 0 then buffer 1.
  - Unload order is buffer 0 then buffer 1.
- **Overflow**: hold `iOUT_READY`=0 and feed 40 samples.
  - 32 are written; 8 are dropped.
  - `oOVF`=1 and `oDROP_CNT`=8; no write to a BUSY or DONE buffer.
- **Backpressure**: toggle `iOUT_READY` every cycle.
  - Each index 0..15 is presented exactly once, held while not ready.
- **RDY handshake**:
  - RDY stays high for 3 cycles after START: no DONE until a low-then-high RDY sequence is seen.
  - RDY initially low while FULL: START is withheld until RDY=1.
- **Reset mid-FHT**: assert `iRESET` in WAIT_DONE.
  - All outputs return to reset values.
  - The next 16 samples load into buffer 0 from address 0.
